// File: rtl/clock_lock_supervisor.sv
// clock_lock_supervisor: sequences MMCM reset, waits for lock with timeout and
// retry, qualifies lock stability, and issues a clean ready for the pixel domain.
// Also keeps saturating debug counts of lock timeouts and run-time lock losses.
module clock_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_locked,
    output logic             o_mmcm_rst,
    output logic             o_ready,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retry_count,
    output logic [CNT_W-1:0] o_loss_count
);

    // Cycle counter must hold the largest "last cycle" index of any state.
    localparam int unsigned MAX_RT  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CYC_MAX = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam int unsigned ATT_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CYC_W-1:0] RST_LAST     = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [ATT_W-1:0] ATT_LAST     = ATT_W'(MAX_RETRIES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               sync_meta;
    logic               lk;
    logic [CYC_W-1:0]   cyc;
    logic [ATT_W-1:0]   attempts;
    logic [ATT_W-1:0]   attempts_d;
    logic               timeout;
    logic               loss;
    logic               mmcm_rst_d;
    logic               ready_d;
    logic               fault_d;
    logic [CNT_W-1:0]   retry_count_d;
    logic [CNT_W-1:0]   loss_count_d;

    // Two-flop synchronizer for the asynchronous MMCM locked status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= 1'b0;
            lk        <= 1'b0;
        end else begin
            sync_meta <= i_locked;
            lk        <= sync_meta;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Shared cycle counter: cleared on every state entry, saturates otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cyc <= '0;
        end else if (next_state != state) begin
            cyc <= '0;
        end else if (cyc != '1) begin
            cyc <= cyc + CYC_W'(1);
        end
    end

    // Timeout only fires when lock is absent in the final waiting cycle.
    assign timeout = (state == S_WAIT_LOCK) && !lk && (cyc == TIMEOUT_LAST);
    assign loss    = (state == S_RUN) && !lk;

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET: begin
                if (cyc == RST_LAST) begin
                    next_state = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (lk) begin
                    next_state = S_STABLE;
                end else if (timeout) begin
                    next_state = (attempts == ATT_LAST) ? S_FAULT : S_RESET;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    next_state = S_WAIT_LOCK;
                end else if (cyc == STABLE_LAST) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    next_state = S_RESET;
                end
            end
            S_FAULT: begin
                next_state = S_FAULT;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    // Output and counter next values, decoded from the state being entered.
    always_comb begin
        mmcm_rst_d    = (next_state == S_RESET) || (next_state == S_FAULT);
        ready_d       = (next_state == S_RUN);
        fault_d       = (next_state == S_FAULT);
        retry_count_d = o_retry_count;
        loss_count_d  = o_loss_count;
        attempts_d    = attempts;
        if (timeout) begin
            attempts_d = attempts + ATT_W'(1);
            if (o_retry_count != CNT_SAT) begin
                retry_count_d = o_retry_count + CNT_W'(1);
            end
        end
        if ((state == S_STABLE) && (next_state == S_RUN)) begin
            attempts_d = '0;
        end
        if (loss && (o_loss_count != CNT_SAT)) begin
            loss_count_d = o_loss_count + CNT_W'(1);
        end
    end

    // Registered outputs and diagnostic counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mmcm_rst    <= 1'b1;
            o_ready       <= 1'b0;
            o_fault       <= 1'b0;
            o_retry_count <= '0;
            o_loss_count  <= '0;
            attempts      <= '0;
        end else begin
            o_mmcm_rst    <= mmcm_rst_d;
            o_ready       <= ready_d;
            o_fault       <= fault_d;
            o_retry_count <= retry_count_d;
            o_loss_count  <= loss_count_d;
            attempts      <= attempts_d;
        end
    end

endmodule

// File: tb/tb_clock_lock_supervisor.sv
// Directed bench for clock_lock_supervisor using small test parameters.
module tb_clock_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       mmcm_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [3:0] loss_count;

    int n_tests = 0;
    int n_fail  = 0;

    clock_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_locked     (locked),
        .o_mmcm_rst   (mmcm_rst),
        .o_ready      (ready),
        .o_fault      (fault),
        .o_retry_count(retry_count),
        .o_loss_count (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts falling edges while o_mmcm_rst stays at lvl; -1 if bound expires.
    task automatic wait_mmcm(input logic lvl, output int n);
        n = 0;
        while (mmcm_rst === lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n = -1;
    endtask

    // Counts falling edges until o_ready rises; -1 if bound expires.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) n = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Ready must never coexist with fault or an asserted MMCM reset.
    always @(negedge clk) begin
        if (!rst) check("excl", 32'(ready & (fault | mmcm_rst)), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_loss;
        logic seen;
        rst    = 1'b1;
        locked = 1'b0;
        #1;
        check("rst_mmcm",  32'(mmcm_rst), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_loss",  32'(loss_count), 32'd0);

        // 1: clean bring-up
        @(negedge clk);
        rst = 1'b0;
        wait_mmcm(1'b1, n);
        check("t1_rst_len", n, 32'd4);
        repeat (10) @(negedge clk);
        check("t1_no_ready", 32'(ready), 32'd0);
        locked = 1'b1;
        wait_ready(n);
        check("t1_ready_lat", n, 32'd11);
        check("t1_retry", 32'(retry_count), 32'd0);
        check("t1_loss", 32'(loss_count), 32'd0);

        // 2: single timeout then lock
        locked = 1'b0;
        do_reset();
        wait_mmcm(1'b1, n);
        check("t2_rst_len", n, 32'd4);
        wait_mmcm(1'b0, n);
        check("t2_timeout", n, 32'd32);
        check("t2_retry", 32'(retry_count), 32'd1);
        wait_mmcm(1'b1, n);
        check("t2_repulse", n, 32'd4);
        locked = 1'b1;
        wait_ready(n);
        check("t2_ready_lat", n, 32'd11);
        check("t2_fault", 32'(fault), 32'd0);
        check("t2_retry_end", 32'(retry_count), 32'd1);

        // 3: retries exhausted
        locked = 1'b0;
        do_reset();
        wait_mmcm(1'b1, n);
        wait_mmcm(1'b0, n);
        check("t3_to1", n, 32'd32);
        wait_mmcm(1'b1, n);
        check("t3_repulse", n, 32'd4);
        wait_mmcm(1'b0, n);
        check("t3_to2", n, 32'd32);
        check("t3_fault", 32'(fault), 32'd1);
        check("t3_mmcm", 32'(mmcm_rst), 32'd1);
        check("t3_retry", 32'(retry_count), 32'd2);
        locked = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_fault_hold", 32'(fault), 32'd1);
        check("t3_mmcm_hold", 32'(mmcm_rst), 32'd1);
        check("t3_ready_hold", 32'(ready), 32'd0);
        check("t3_retry_hold", 32'(retry_count), 32'd2);

        // 4: unstable lock
        locked = 1'b0;
        do_reset();
        wait_mmcm(1'b1, n);
        check("t4_rst_len", n, 32'd4);
        check("t4_fault_clr", 32'(fault), 32'd0);
        seen = 1'b0;
        locked = 1'b1;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ready;
        end
        locked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ready;
        end
        check("t4_no_ready", 32'(seen), 32'd0);
        locked = 1'b1;
        wait_ready(n);
        check("t4_ready_lat", n, 32'd11);
        check("t4_retry", 32'(retry_count), 32'd0);
        check("t4_loss", 32'(loss_count), 32'd0);

        // 5: losses in RUN, saturating after 15
        for (int i = 1; i <= 16; i++) begin
            exp_loss = (i > 15) ? 15 : i;
            @(negedge clk);
            locked = 1'b0;
            @(negedge clk);
            locked = 1'b1;
            check("t5_ready_e1", 32'(ready), 32'd1);
            @(negedge clk);
            check("t5_ready_e2", 32'(ready), 32'd1);
            @(negedge clk);
            check("t5_ready_e3", 32'(ready), 32'd0);
            check("t5_mmcm_e3", 32'(mmcm_rst), 32'd1);
            check("t5_loss", 32'(loss_count), 32'(exp_loss));
            wait_mmcm(1'b1, n);
            check("t5_rst_len", n, 32'd4);
            wait_ready(n);
            check("t5_relock", n, 32'd9);
        end
        check("t5_retry", 32'(retry_count), 32'd0);

        // 6: async reset while in STABLE
        @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        repeat (2) @(negedge clk);
        wait_mmcm(1'b1, n);
        check("t6_rst_len", n, 32'd4);
        repeat (3) @(negedge clk);
        check("t6_pre_ready", 32'(ready), 32'd0);
        check("t6_pre_mmcm", 32'(mmcm_rst), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_mmcm", 32'(mmcm_rst), 32'd1);
        check("t6_ready", 32'(ready), 32'd0);
        check("t6_fault", 32'(fault), 32'd0);
        check("t6_loss", 32'(loss_count), 32'd0);
        check("t6_retry", 32'(retry_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_mmcm(1'b1, n);
        check("t6_rst_len2", n, 32'd4);
        wait_ready(n);
        check("t6_relock", n, 32'd9);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
